// File: rtl/colorizer_pkg.sv
// Shared constants and types for the colorizer: default colour format,
// transparency key, blink counter width and the palette reset image.
package colorizer_pkg;

  localparam int COLOR_W_DEF = 12;
  localparam logic [COLOR_W_DEF-1:0] TRANSP_KEY_DEF = 12'h000;
  localparam int BLINK_CNT_W = 8;

  // Power-up palette: white, black, brown, red. Deeper palettes start black.
  localparam int PAL_RESET_N = 4;
  localparam logic [COLOR_W_DEF-1:0] PAL_RESET [PAL_RESET_N] = '{
    12'hFFF, 12'h000, 12'h840, 12'hF00
  };

  // Blink phase: icons with blink_en set are hidden while in PHASE_HIDE.
  typedef enum logic {
    PHASE_SHOW = 1'b0,
    PHASE_HIDE = 1'b1
  } blink_phase_e;

  // Reset value of palette entry idx; entries past the table are black.
  function automatic logic [COLOR_W_DEF-1:0] pal_reset_value(input int idx);
    logic [1:0] sel;
    sel = idx[1:0];
    if (idx < PAL_RESET_N) return PAL_RESET[sel];
    return '0;
  endfunction

endpackage

// File: rtl/colorizer_palette.sv
// Writable palette register file: synchronous write, combinational read.
// A read of the entry being written in the same cycle sees the old value.
module colorizer_palette
  import colorizer_pkg::*;
#(
  parameter int MAP_BITS = 2,
  parameter int COLOR_W  = COLOR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [MAP_BITS-1:0] waddr,
  input  logic [COLOR_W-1:0]  wdata,
  input  logic [MAP_BITS-1:0] raddr,
  output logic [COLOR_W-1:0]  rdata
);

  localparam int DEPTH = 2 ** MAP_BITS;

  logic [COLOR_W-1:0] mem [DEPTH];

  // Palette storage: reload the reset image on reset, otherwise accept writes.
  // NOTE: this storage is reset on purpose -- the palette must come back to a
  // known image after reset, so it is built from flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= COLOR_W'(pal_reset_value(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read; the write lands at the edge, so collisions read old data.
  assign rdata = mem[raddr];

endmodule

// File: rtl/colorizer_v3.sv
// Pipelined colorizer: merges NUM_ICONS prioritised icon layers over a
// palette-mapped world pixel, with frame-based blinking. Two-cycle latency,
// one pixel per clock, video_on travels with the pixel so blanking stays aligned.
module colorizer_v3
  import colorizer_pkg::*;
#(
  parameter int                    NUM_ICONS    = 2,
  parameter int                    MAP_BITS     = 2,
  parameter int                    COLOR_W      = COLOR_W_DEF,
  parameter logic [COLOR_W-1:0]    TRANSP_KEY   = COLOR_W'(TRANSP_KEY_DEF),
  parameter int                    BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_ICONS*COLOR_W-1:0]   icon_pix,
  input  logic [NUM_ICONS-1:0]           icon_vld,
  input  logic [NUM_ICONS-1:0]           blink_en,
  input  logic [MAP_BITS-1:0]            world_pixel,
  input  logic                           video_on,
  input  logic                           frame_tick,
  input  logic                           pal_we,
  input  logic [MAP_BITS-1:0]            pal_addr,
  input  logic [COLOR_W-1:0]             pal_wdata,
  output logic [COLOR_W/3-1:0]           VGA_R,
  output logic [COLOR_W/3-1:0]           VGA_G,
  output logic [COLOR_W/3-1:0]           VGA_B
);

  localparam int CH_W = COLOR_W / 3;
  localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_FRAMES - 1);

  logic [BLINK_CNT_W-1:0] blink_cnt;
  blink_phase_e           blink_phase;

  logic [NUM_ICONS-1:0]   opaque;
  logic [COLOR_W-1:0]     sel_color_d;
  logic                   any_opaque_d;
  logic [COLOR_W-1:0]     pal_color_d;

  logic [COLOR_W-1:0]     sel_color_s1;
  logic [COLOR_W-1:0]     pal_color_s1;
  logic                   any_opaque_s1;
  logic                   video_on_s1;

  logic [COLOR_W-1:0]     rgb_s2;

  // Blink timing: count frames, flip phase every BLINK_FRAMES ticks, so the
  // phase only ever changes at a frame boundary.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= PHASE_SHOW;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= (blink_phase == PHASE_SHOW) ? PHASE_HIDE : PHASE_SHOW;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Per-icon opacity: covering, not the transparent key, and not blinked off.
  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_ICONS; i++) begin
      opaque[i] = icon_vld[i]
                  && (icon_pix[i*COLOR_W +: COLOR_W] != TRANSP_KEY)
                  && !(blink_en[i] && (blink_phase == PHASE_HIDE));
    end
  end

  // Priority select: scanning from the lowest priority up, so the
  // lowest-index opaque icon is the last (winning) assignment.
  always_comb begin
    sel_color_d  = '0;
    any_opaque_d = 1'b0;
    for (int i = NUM_ICONS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        sel_color_d  = icon_pix[i*COLOR_W +: COLOR_W];
        any_opaque_d = 1'b1;
      end
    end
  end

  colorizer_palette #(
    .MAP_BITS (MAP_BITS),
    .COLOR_W  (COLOR_W)
  ) u_palette (
    .clk   (clk),
    .reset (reset),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_wdata),
    .raddr (world_pixel),
    .rdata (pal_color_d)
  );

  // Stage 1: register icon choice, palette colour and blanking for this pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_color_s1  <= '0;
      pal_color_s1  <= '0;
      any_opaque_s1 <= 1'b0;
      video_on_s1   <= 1'b0;
    end else begin
      sel_color_s1  <= sel_color_d;
      pal_color_s1  <= pal_color_d;
      any_opaque_s1 <= any_opaque_d;
      video_on_s1   <= video_on;
    end
  end

  // Stage 2: blank outside the active region, else icon over world colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_s2 <= '0;
    end else if (!video_on_s1) begin
      rgb_s2 <= '0;
    end else begin
      rgb_s2 <= any_opaque_s1 ? sel_color_s1 : pal_color_s1;
    end
  end

  assign VGA_R = rgb_s2[3*CH_W-1 -: CH_W];
  assign VGA_G = rgb_s2[2*CH_W-1 -: CH_W];
  assign VGA_B = rgb_s2[CH_W-1:0];

endmodule

// File: tb/tb_colorizer_v3.sv
// Self-checking bench for colorizer_v3: a driver pushes the expected colour of
// every presented pixel into a scoreboard queue, and a monitor pops and
// compares once that pixel reaches the VGA outputs.
module tb_colorizer_v3;

  localparam int NI = 2;
  localparam int MB = 2;
  localparam int CW = 12;
  localparam int BF = 2;

  logic            clk;
  logic            reset;
  logic [NI*CW-1:0] icon_pix;
  logic [NI-1:0]   icon_vld;
  logic [NI-1:0]   blink_en;
  logic [MB-1:0]   world_pixel;
  logic            video_on;
  logic            frame_tick;
  logic            pal_we;
  logic [MB-1:0]   pal_addr;
  logic [CW-1:0]   pal_wdata;
  logic [3:0]      vga_r, vga_g, vga_b;
  logic [11:0]     vga;

  assign vga = {vga_r, vga_g, vga_b};

  colorizer_v3 #(
    .NUM_ICONS    (NI),
    .MAP_BITS     (MB),
    .COLOR_W      (CW),
    .TRANSP_KEY   (12'h000),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .icon_pix    (icon_pix),
    .icon_vld    (icon_vld),
    .blink_en    (blink_en),
    .world_pixel (world_pixel),
    .video_on    (video_on),
    .frame_tick  (frame_tick),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          tag;
    logic [11:0] rgb;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;

  // Reference state: palette contents and frame ticks seen since reset.
  logic [11:0] model_pal [4];
  int          tick_total;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s @cycle %0d: got %03h expected %03h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    model_pal[0] = 12'hFFF;
    model_pal[1] = 12'h000;
    model_pal[2] = 12'h840;
    model_pal[3] = 12'hF00;
    tick_total   = 0;
  endtask

  // Colour the display should show for the inputs currently presented.
  function automatic logic [11:0] model_rgb();
    logic        hidden;
    logic [11:0] c;
    if (!video_on) return 12'h000;
    hidden = ((tick_total / BF) % 2) == 1;
    for (int i = 0; i < NI; i++) begin
      c = icon_pix[i*CW +: CW];
      if (icon_vld[i] && c != 12'h000 && !(blink_en[i] && hidden)) return c;
    end
    return model_pal[world_pixel];
  endfunction

  // Present the current inputs for one clock, recording the expected output.
  task automatic step();
    exp_t e;
    e.tag = cyc + 1;
    e.rgb = reset ? 12'h000 : model_rgb();
    sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (pal_we) model_pal[pal_addr] = pal_wdata;
      if (frame_tick) tick_total++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset       = 1'b0;
    icon_pix    = '0;
    icon_vld    = '0;
    blink_en    = '0;
    world_pixel = '0;
    video_on    = 1'b1;
    frame_tick  = 1'b0;
    pal_we      = 1'b0;
    pal_addr    = '0;
    pal_wdata   = '0;
  endtask

  task automatic set_px(input logic [1:0] vld, input logic [11:0] p0, input logic [11:0] p1,
                        input logic [1:0] blink, input logic [1:0] world, input logic vo);
    icon_vld    = vld;
    icon_pix    = {p1, p0};
    blink_en    = blink;
    world_pixel = world;
    video_on    = vo;
  endtask

  function automatic logic [11:0] rand_color();
    case ($urandom_range(5))
      0, 1:    return 12'h000;
      2:       return 12'h0F0;
      3:       return 12'hABC;
      4:       return 12'hF00;
      default: return 12'($urandom);
    endcase
  endfunction

  // Monitor: during reset the outputs must be black; otherwise compare the
  // pixel captured two edges ago against its scoreboard entry.
  initial begin
    exp_t e;
    logic rst_s;
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = reset;
      #1;
      if (rst_s) begin
        check("reset_out", vga, 12'h000);
        while (sb.size() > 0 && sb[0].tag < cyc) void'(sb.pop_front());
      end else begin
        while (sb.size() > 0 && sb[0].tag < cyc - 1) begin
          e = sb.pop_front();
          compared++;
          mismatched++;
          $display("FAIL stale_entry @cycle %0d: entry tag %0d never compared", cyc, e.tag);
        end
        if (sb.size() > 0 && sb[0].tag == cyc - 1) begin
          e = sb.pop_front();
          check("pixel", vga, e.rgb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle();
    reset = 1'b1;

    // Reset, then an idle brown world pixel: black until the pipeline fills.
    repeat (2) step();
    reset = 1'b0;
    set_px(2'b00, 12'h000, 12'h000, 2'b00, 2'd2, 1'b1);
    repeat (4) step();
    check("world2_brown", vga, 12'h840);

    // Icon priority, then icon 0 made transparent.
    set_px(2'b11, 12'h0F0, 12'h00F, 2'b00, 2'd0, 1'b1);
    repeat (3) step();
    set_px(2'b11, 12'h000, 12'h00F, 2'b00, 2'd0, 1'b1);
    repeat (3) step();
    check("icon1_through", vga, 12'h00F);

    // Palette write colliding with a lookup of the same entry.
    set_px(2'b00, 12'h000, 12'h000, 2'b00, 2'd1, 1'b1);
    pal_we = 1'b1; pal_addr = 2'd1; pal_wdata = 12'h123;
    step();
    pal_we = 1'b0;
    repeat (3) step();
    check("pal_written", vga, 12'h123);

    // Blink: icon 0 blinks over white, icon 1 underneath does not.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) set_px(2'b01, 12'hF00, 12'h000, 2'b01, 2'd0, 1'b1);
      else           set_px(2'b11, 12'hF00, 12'h0F0, 2'b01, 2'd0, 1'b1);
      for (int t = 0; t < 8; t++) begin
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (3) step();
      end
    end
    // Phase has no visible effect once nothing blinks.
    set_px(2'b01, 12'hF00, 12'h000, 2'b00, 2'd0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (2) step();
    end

    // Blanking follows video_on with the same latency.
    for (int k = 0; k < 8; k++) begin
      set_px(2'b01, 12'hABC, 12'h000, 2'b00, 2'd3, (8'b1101_0011 >> k) & 8'h1);
      step();
    end

    // Reset mid-line with icons active: palette and phase return to reset.
    frame_tick = 1'b1;
    set_px(2'b11, 12'hF00, 12'h0F0, 2'b01, 2'd1, 1'b1);
    step();
    frame_tick = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_px(2'b11, 12'hF00, 12'h0F0, 2'b01, 2'd1, 1'b1);
    repeat (3) step();
    set_px(2'b00, 12'h000, 12'h000, 2'b00, 2'd1, 1'b1);
    repeat (3) step();
    check("pal1_after_reset", vga, 12'h000);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(199) == 0);
      icon_pix    = {rand_color(), rand_color()};
      icon_vld    = 2'($urandom);
      blink_en    = 2'($urandom);
      world_pixel = 2'($urandom);
      video_on    = ($urandom_range(7) != 0);
      frame_tick  = ($urandom_range(5) == 0);
      pal_we      = ($urandom_range(9) == 0);
      pal_addr    = 2'($urandom);
      pal_wdata   = 12'($urandom);
      step();
    end

    idle();
    repeat (2) @(posedge clk);
    #2;
    check("sb_drain", 12'(sb.size()), 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
